// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, DBIT data bits LSB-first, registered strobe and framing flag
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done,
  output logic            frame_err
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          state;
  logic [4:0]      s;
  logic [3:0]      n;
  logic [DBIT-1:0] b;
  logic            rx_m, rx_s, rx_p;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_m, rx_s, rx_p} <= 3'b111;
    else {rx_m, rx_s, rx_p} <= {rx, rx_m, rx_s};
  // the falling-edge check in IDLE ignores tick, so a coincident tick is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      b         <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (state)
        IDLE:
          if (rx_p && !rx_s) begin
            state <= START;
            s     <= '0;
          end
        START:
          if (tick) begin
            if (s == 5'd7) begin
              state <= rx_s ? IDLE : DATA;
              s     <= '0;
              n     <= '0;
            end else s <= s + 5'd1;
          end
        DATA:
          if (tick) begin
            if (s == 5'd15) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              if (n == 4'(DBIT-1)) state <= STOP;
              else n <= n + 4'd1;
            end else s <= s + 5'd1;
          end
        STOP:
          if (tick) begin
            if (s == 5'(SB_TICK-1)) begin
              dout      <= b;
              frame_err <= ~rx_s;
              rx_done   <= 1'b1;
              state     <= IDLE;
            end else s <= s + 5'd1;
          end
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx, default and DBIT=7/SB_TICK=32 instances, 64 clk per bit
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx7 = 1'b1;
  logic [1:0] tcnt = 2'd0;
  logic       tick;
  logic [7:0] dout;
  logic [6:0] dout7;
  logic       rx_done, frame_err, rx_done7, frame_err7;
  logic       done_d = 1'b0, done7_d = 1'b0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  logic [8:0] q[$];
  logic [7:0] q7[$];
  int         done_cyc[$];
  int         done7_cyc = -1;

  always #5 clk = ~clk;
  always @(posedge clk) begin
    tcnt <= tcnt + 2'd1;
    cyc  <= cyc + 1;
  end
  assign tick = (tcnt == 2'd3);

  uart_rx dut (.clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
               .dout(dout), .rx_done(rx_done), .frame_err(frame_err));
  uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (.clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx7),
               .dout(dout7), .rx_done(rx_done7), .frame_err(frame_err7));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    done_d <= rx_done;
    if (rx_done) begin
      chk("done_width", {31'd0, done_d}, 0);
      done_cyc.push_back(cyc);
      if (q.size() == 0) chk("unexpected_done", {23'd0, frame_err, dout}, 32'hFFFF_FFFF);
      else begin
        logic [8:0] e;
        e = q.pop_front();
        chk("dout", {24'd0, dout}, {24'd0, e[7:0]});
        chk("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
      end
    end
  end

  always @(negedge clk) begin
    done7_d <= rx_done7;
    if (rx_done7) begin
      chk("done7_width", {31'd0, done7_d}, 0);
      done7_cyc = cyc;
      if (q7.size() == 0) chk("unexpected_done7", {24'd0, frame_err7, dout7}, 32'hFFFF_FFFF);
      else begin
        logic [7:0] e;
        e = q7.pop_front();
        chk("dout7", {25'd0, dout7}, {25'd0, e[6:0]});
        chk("frame_err7", {31'd0, frame_err7}, {31'd0, e[7]});
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx7 = v;
    else rx = v;
  endtask

  task automatic send(input logic [8:0] d, input int nb, input logic stop, input bit sel);
    set_line(sel, 1'b0);
    hold(64);
    for (int i = 0; i < nb; i++) begin
      set_line(sel, d[i]);
      hold(64);
    end
    set_line(sel, stop);
    hold(64);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    hold(3);
    chk("reset_dout", {24'd0, dout}, 0);
    chk("reset_done", {31'd0, rx_done}, 0);
    chk("reset_ferr", {31'd0, frame_err}, 0);
    rst_n = 1'b1;
    hold(20);
    // nominal frame, then hold check
    q.push_back({1'b0, 8'hA5});
    send(9'h0A5, 8, 1'b1, 1'b0);
    hold(200);
    chk("dout_held", {24'd0, dout}, 32'hA5);
    // start glitch of 12 clk, must be discarded
    rx = 1'b0;
    hold(12);
    rx = 1'b1;
    hold(1000);
    q.push_back({1'b0, 8'h3C});
    send(9'h03C, 8, 1'b1, 1'b0);
    hold(100);
    // framing error followed by a stuck-low line
    q.push_back({1'b1, 8'h55});
    send(9'h055, 8, 1'b0, 1'b0);
    hold(1000);
    rx = 1'b1;
    hold(200);
    q.push_back({1'b0, 8'h0F});
    send(9'h00F, 8, 1'b1, 1'b0);
    hold(100);
    // back-to-back frames, no idle gap
    done_cyc.delete();
    q.push_back({1'b0, 8'h00});
    q.push_back({1'b0, 8'hFF});
    send(9'h000, 8, 1'b1, 1'b0);
    send(9'h0FF, 8, 1'b1, 1'b0);
    hold(100);
    chk("b2b_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      t0 = done_cyc[1] - done_cyc[0];
      chk("b2b_spacing_ok", {31'd0, (t0 >= 636 && t0 <= 644)}, 1);
    end
    // reset in the middle of a frame after 4 data bits
    rx = 1'b0;
    hold(64);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      hold(64);
    end
    rx = 1'b1;
    rst_n = 1'b0;
    hold(3);
    rst_n = 1'b1;
    hold(1000);
    chk("midreset_dout", {24'd0, dout}, 0);
    chk("midreset_ferr", {31'd0, frame_err}, 0);
    q.push_back({1'b0, 8'h81});
    send(9'h081, 8, 1'b1, 1'b0);
    hold(100);
    // variant instance: 7 data bits, 2 stop bits
    q7.push_back({1'b0, 7'h5A});
    t0 = cyc;
    send(9'h05A, 7, 1'b1, 1'b1);
    hold(200);
    chk("v7_seen", {31'd0, done7_cyc >= 0}, 1);
    if (done7_cyc >= 0)
      chk("v7_latency_ok", {31'd0, (done7_cyc - t0 >= 605 && done7_cyc - t0 <= 614)}, 1);
    for (int i = 0; i < 2000 && (q.size() + q7.size()) != 0; i++) hold(1);
    chk("queues_drained", q.size() + q7.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
